// File: rtl/store_drain_responder_pkg.sv
// Shared types and helpers for the store-drain responder: FSM states, word geometry,
// and the byte-lane merge used on commit.
package mem_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    function automatic logic [31:0] merge_lanes(input logic [31:0]           old_word,
                                                input logic [31:0]           new_word,
                                                input logic [WORD_BYTES-1:0] be);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/store_drain_responder_if.sv
// Drain handshake, load read port and status signals between the store buffer (master)
// and the memory-side responder (slave).
interface store_drain_responder_if;
    import mem_pkg::*;

    logic                  mem_valid;
    logic [31:0]           mem_addr;
    logic [31:0]           mem_data;
    logic [WORD_BYTES-1:0] mem_byte_en;
    logic                  mem_ready;
    logic                  rd_req;
    logic [31:0]           rd_addr;
    logic                  rd_valid;
    logic [31:0]           rd_data;
    logic                  busy;
    logic                  wr_err;

    modport master (
        output mem_valid, mem_addr, mem_data, mem_byte_en, rd_req, rd_addr,
        input  mem_ready, rd_valid, rd_data, busy, wr_err
    );

    modport slave (
        input  mem_valid, mem_addr, mem_data, mem_byte_en, rd_req, rd_addr,
        output mem_ready, rd_valid, rd_data, busy, wr_err
    );

endinterface

// File: rtl/store_drain_responder_ram.sv
// DEPTH x 32 word array with one lane-masked write port and one registered read port.
// The read register samples the array before the same-edge write lands (read-before-write).
module byte_masked_ram
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [31:0]           i_wdata,
    input  logic [WORD_BYTES-1:0] i_wbe,
    input  logic                  i_re,
    input  logic [AW-1:0]         i_raddr,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // Contents are deliberately not reset so committed data survives a reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= merge_lanes(r_mem[i_waddr], i_wdata, i_wbe);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/store_drain_responder.sv
// Memory-side responder for the store buffer drain: captures one store in IDLE, waits
// WRITE_LATENCY BUSY cycles, acknowledges in ACK and commits; also serves a 1-cycle read port.
module store_drain_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH         = 256,
    parameter int unsigned WRITE_LATENCY = 3,
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000
) (
    input logic                    clk,
    input logic                    reset,
    store_drain_responder_if.slave bus
);

    localparam int unsigned       IDX_W     = $clog2(DEPTH);
    localparam int unsigned       CNT_W     = (WRITE_LATENCY > 1) ? $clog2(WRITE_LATENCY) : 1;
    localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(WRITE_LATENCY - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [29:0]       BASE_WORD = BASE_ADDR[31:2];

    state_t                r_state;
    state_t                w_state_d;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_d;
    logic                  w_capture;
    logic [29:0]           r_addr;
    logic [31:0]           r_data;
    logic [WORD_BYTES-1:0] r_be;

    logic [29:0]           w_wr_off;
    logic [29:0]           w_rd_off;
    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic                  w_commit;
    logic                  r_rd_valid;
    logic                  r_rd_oor;
    logic [31:0]           w_ram_rdata;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_capture = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.mem_valid) begin
                    w_capture = 1'b1;
                    w_cnt_d   = CNT_INIT;
                    w_state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_d = ST_ACK;
                end else begin
                    w_cnt_d = r_cnt - CNT_ONE;
                end
            end
            ST_ACK:  w_state_d = ST_IDLE;
            default: w_state_d = ST_IDLE;
        endcase
    end

    // A reset in BUSY/ACK simply discards the latched store; the requester retries it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_be    <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (w_capture) begin
                r_addr <= bus.mem_addr[31:2];
                r_data <= bus.mem_data;
                r_be   <= bus.mem_byte_en;
            end
        end
    end

    // Word-granular decode: in range iff the word offset fits in IDX_W bits.
    assign w_wr_off      = r_addr - BASE_WORD;
    assign w_rd_off      = bus.rd_addr[31:2] - BASE_WORD;
    assign w_wr_in_range = (w_wr_off[29:IDX_W] == '0);
    assign w_rd_in_range = (w_rd_off[29:IDX_W] == '0);
    assign w_commit      = (r_state == ST_ACK) && w_wr_in_range;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_oor   <= 1'b0;
        end else begin
            r_rd_valid <= bus.rd_req;
            if (bus.rd_req) begin
                r_rd_oor <= !w_rd_in_range;
            end
        end
    end

    byte_masked_ram #(
        .DEPTH(DEPTH),
        .AW   (IDX_W)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .i_we   (w_commit),
        .i_waddr(w_wr_off[IDX_W-1:0]),
        .i_wdata(r_data),
        .i_wbe  (r_be),
        .i_re   (bus.rd_req && w_rd_in_range),
        .i_raddr(w_rd_off[IDX_W-1:0]),
        .o_rdata(w_ram_rdata)
    );

    assign bus.mem_ready = (r_state == ST_ACK);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.wr_err    = (r_state == ST_ACK) && !w_wr_in_range;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_data   = r_rd_oor ? '0 : w_ram_rdata;

endmodule

// File: tb/tb_store_drain_responder.sv
// Bench for store_drain_responder: directed table, multi-cycle corner sequences, and a
// randomized run checked against a transaction-level memory model.
module tb_store_drain_responder;
    import mem_pkg::*;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned WL    = 3;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    store_drain_responder_if sd();

    store_drain_responder #(
        .DEPTH        (DEPTH),
        .WRITE_LATENCY(WL),
        .BASE_ADDR    (BASE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (sd.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [31:0] mdl [DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return r;
    endfunction

    function automatic bit addr_ok(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < 32'(DEPTH * 4);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off >> 2);
    endfunction

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        if ($urandom_range(0, 7) == 0) begin
            a = BASE + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 63));
        end else begin
            a = BASE + 32'(4 * $urandom_range(0, 15));
        end
        return a + 32'($urandom_range(0, 3));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                            output int lat, output logic err, output logic bsy1,
                            output logic rdy_after);
        sd.mem_valid   = 1'b1;
        sd.mem_addr    = a;
        sd.mem_data    = d;
        sd.mem_byte_en = be;
        step();
        bsy1 = sd.busy;
        lat  = 1;
        while (!sd.mem_ready && lat < 20) begin
            step();
            lat++;
        end
        err          = sd.wr_err;
        sd.mem_valid = 1'b0;
        step();
        rdy_after = sd.mem_ready;
        if (addr_ok(a)) mdl[word_of(a)] = lane_merge(mdl[word_of(a)], d, be);
    endtask

    task automatic do_read(input logic [31:0] a, output logic v, output logic [31:0] d);
        sd.rd_req  = 1'b1;
        sd.rd_addr = a;
        step();
        v         = sd.rd_valid;
        d         = sd.rd_data;
        sd.rd_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic        err, bsy1, rdy_after, v, seen;
        logic [31:0] d;
        int          rdy_cyc [3];
        int          k;
        logic [31:0] b2b_addr [3];
        logic [31:0] b2b_data [3];
        bit          pend;
        int          cap_c, ack_c;
        logic [31:0] p_addr, p_data;
        logic [3:0]  p_be;
        logic        exp_rd_valid;
        logic [31:0] exp_rd_data;

        tbl[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 1'b0};
        tbl[1] = '{32'h0000_0020, 32'h1122_3344, 4'b1111, 32'h1122_3344, 1'b0};
        tbl[2] = '{32'h0000_0020, 32'hAABB_CCDD, 4'b0101, 32'h11BB_33DD, 1'b0};
        tbl[3] = '{32'h0000_0020, 32'h0000_0000, 4'b0000, 32'h11BB_33DD, 1'b0};
        tbl[4] = '{32'h0000_0400, 32'h1234_5678, 4'b1111, 32'h0000_0000, 1'b1};
        tbl[5] = '{32'h0000_0013, 32'h55AA_55AA, 4'b1010, 32'h55AD_55EF, 1'b0};
        tbl[6] = '{32'hFFFF_FFFC, 32'h9999_9999, 4'b1111, 32'h0000_0000, 1'b1};

        reset          = 1'b1;
        sd.mem_valid   = 1'b0;
        sd.mem_addr    = '0;
        sd.mem_data    = '0;
        sd.mem_byte_en = '0;
        sd.rd_req      = 1'b0;
        sd.rd_addr     = '0;
        step();
        step();
        check("reset mem_ready", 32'(sd.mem_ready), 32'd0);
        check("reset busy", 32'(sd.busy), 32'd0);
        check("reset wr_err", 32'(sd.wr_err), 32'd0);
        check("reset rd_valid", 32'(sd.rd_valid), 32'd0);
        check("reset rd_data", sd.rd_data, 32'd0);
        reset = 1'b0;
        step();
        check("post-reset busy", 32'(sd.busy), 32'd0);

        // Array is not cleared by reset: give every word a known value first.
        for (int i = 0; i < int'(DEPTH); i++) begin
            do_store(BASE + 32'(4 * i), 32'h0, 4'hF, lat, err, bsy1, rdy_after);
        end

        for (int i = 0; i < 7; i++) begin
            do_store(tbl[i].addr, tbl[i].data, tbl[i].be, lat, err, bsy1, rdy_after);
            check($sformatf("t%0d latency", i), 32'(lat), 32'(WL + 1));
            check($sformatf("t%0d busy at T+1", i), 32'(bsy1), 32'd1);
            check($sformatf("t%0d wr_err", i), 32'(err), 32'(tbl[i].exp_err));
            check($sformatf("t%0d mem_ready one cycle", i), 32'(rdy_after), 32'd0);
            do_read(tbl[i].addr, v, d);
            check($sformatf("t%0d rd_valid", i), 32'(v), 32'd1);
            check($sformatf("t%0d rd_data", i), d, tbl[i].exp_rd);
        end
        do_read(32'h0000_0000, v, d);
        check("oor no alias word 0", d, 32'h0);
        do_read(32'h0000_03FC, v, d);
        check("oor no alias word 255", d, 32'h0);

        // Back-to-back drain with mem_valid held; fields scrambled while BUSY.
        b2b_addr = '{32'h40, 32'h44, 32'h48};
        b2b_data = '{32'h0101_0101, 32'h0202_0202, 32'h0303_0303};
        k = 0;
        sd.mem_valid   = 1'b1;
        sd.mem_addr    = b2b_addr[0];
        sd.mem_data    = b2b_data[0];
        sd.mem_byte_en = 4'hF;
        for (int t = 0; t < 40 && k < 3; t++) begin
            step();
            if (sd.mem_ready) begin
                rdy_cyc[k] = cyc;
                k++;
                if (k < 3) begin
                    sd.mem_addr    = b2b_addr[k];
                    sd.mem_data    = b2b_data[k];
                    sd.mem_byte_en = 4'hF;
                end else begin
                    sd.mem_valid = 1'b0;
                end
            end else if (sd.busy) begin
                sd.mem_addr    = 32'h40 + 32'(4 * $urandom_range(0, 3));
                sd.mem_data    = $urandom();
                sd.mem_byte_en = 4'($urandom_range(0, 15));
            end
        end
        check("b2b ack count", 32'(k), 32'd3);
        check("b2b gap 0-1", 32'(rdy_cyc[1] - rdy_cyc[0]), 32'(WL + 2));
        check("b2b gap 1-2", 32'(rdy_cyc[2] - rdy_cyc[1]), 32'(WL + 2));
        sd.mem_valid = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            mdl[word_of(b2b_addr[i])] = b2b_data[i];
            do_read(b2b_addr[i], v, d);
            check($sformatf("b2b word %0d", i), d, b2b_data[i]);
        end

        // Read of the target word in the ACK cycle returns the old value.
        sd.mem_valid   = 1'b1;
        sd.mem_addr    = 32'h30;
        sd.mem_data    = 32'hCAFE_F00D;
        sd.mem_byte_en = 4'hF;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            step();
            seen = sd.mem_ready;
        end
        check("collision ack seen", 32'(seen), 32'd1);
        sd.mem_valid = 1'b0;
        sd.rd_req    = 1'b1;
        sd.rd_addr   = 32'h30;
        step();
        check("collision rd_valid", 32'(sd.rd_valid), 32'd1);
        check("collision old data", sd.rd_data, 32'h0);
        step();
        check("collision new data", sd.rd_data, 32'hCAFE_F00D);
        sd.rd_req = 1'b0;
        mdl[word_of(32'h30)] = 32'hCAFE_F00D;
        step();

        // Reset in the middle of BUSY drops the store.
        sd.mem_valid   = 1'b1;
        sd.mem_addr    = 32'h50;
        sd.mem_data    = 32'h0BAD_BEEF;
        sd.mem_byte_en = 4'hF;
        step();
        check("rst-busy busy before", 32'(sd.busy), 32'd1);
        step();
        reset        = 1'b1;
        sd.mem_valid = 1'b0;
        #1;
        check("rst-busy busy", 32'(sd.busy), 32'd0);
        check("rst-busy mem_ready", 32'(sd.mem_ready), 32'd0);
        check("rst-busy rd_valid", 32'(sd.rd_valid), 32'd0);
        check("rst-busy rd_data", sd.rd_data, 32'd0);
        step();
        reset = 1'b0;
        seen  = 1'b0;
        for (int t = 0; t < 8; t++) begin
            step();
            seen = seen | sd.mem_ready | sd.busy;
        end
        check("rst-busy no ack", 32'(seen), 32'd0);
        do_read(32'h50, v, d);
        check("rst-busy word unchanged", d, 32'h0);
        do_store(32'h50, 32'h0BAD_BEEF, 4'hF, lat, err, bsy1, rdy_after);
        check("retry latency", 32'(lat), 32'(WL + 1));
        do_read(32'h50, v, d);
        check("retry data", d, 32'h0BAD_BEEF);

        // Randomized run against a transaction-level model.
        do_read(BASE, v, d);
        exp_rd_valid = 1'b1;
        exp_rd_data  = mdl[0];
        pend   = 1'b0;
        cap_c  = 0;
        ack_c  = 0;
        p_addr = '0;
        p_data = '0;
        p_be   = '0;
        for (int c = 0; c < 800; c++) begin
            check($sformatf("rnd c%0d mem_ready", c), 32'(sd.mem_ready), 32'(pend && c == ack_c));
            check($sformatf("rnd c%0d busy", c), 32'(sd.busy), 32'(pend && c > cap_c));
            check($sformatf("rnd c%0d wr_err", c), 32'(sd.wr_err),
                  32'(pend && c == ack_c && !addr_ok(p_addr)));
            check($sformatf("rnd c%0d rd_valid", c), 32'(sd.rd_valid), 32'(exp_rd_valid));
            check($sformatf("rnd c%0d rd_data", c), sd.rd_data, exp_rd_data);

            sd.mem_valid   = ($urandom_range(0, 1) == 1);
            sd.mem_addr    = rnd_addr();
            sd.mem_data    = $urandom();
            sd.mem_byte_en = 4'($urandom_range(0, 15));
            sd.rd_req      = ($urandom_range(0, 2) != 0);
            sd.rd_addr     = rnd_addr();

            exp_rd_valid = sd.rd_req;
            if (sd.rd_req) exp_rd_data = addr_ok(sd.rd_addr) ? mdl[word_of(sd.rd_addr)] : 32'h0;
            if (pend && c == ack_c) begin
                if (addr_ok(p_addr)) mdl[word_of(p_addr)] = lane_merge(mdl[word_of(p_addr)], p_data, p_be);
                pend = 1'b0;
            end else if (!pend && sd.mem_valid) begin
                pend   = 1'b1;
                cap_c  = c;
                ack_c  = c + int'(WL) + 1;
                p_addr = sd.mem_addr;
                p_data = sd.mem_data;
                p_be   = sd.mem_byte_en;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
